// File: rtl/muxn_hs_reg.sv
// rtl/muxn_hs_reg.sv - N-channel registered mux with valid/ready handshake, fixed or round-robin select
// Optional even-parity output o_par is built when MUXN_PARITY_EN is defined.
module muxn_hs_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_mode,
  input  logic [SELW-1:0]        i_sel,
  input  logic [NCH*WIDTH-1:0]   i_data,
  input  logic [NCH-1:0]         i_valid,
  output logic [NCH-1:0]         o_ready,
  output logic [WIDTH-1:0]       o_y,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [SELW-1:0]        o_ch
`ifdef MUXN_PARITY_EN
  ,
  output logic                   o_par
`endif
);

  localparam logic [SELW:0]   NCH_W  = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic [SELW-1:0]  r_ch;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_can_load;
  logic             w_found;
  logic [SELW-1:0]  w_gnt;
  logic [SELW:0]    w_idx;
  logic             w_xfer;
  logic [NCH-1:0]   w_ready;
  logic [WIDTH-1:0] w_data;
  logic [SELW-1:0]  w_next_ptr;

  assign w_can_load = !r_valid || i_ready;

  // Round-robin scans from rr_ptr upward and wraps; the first valid channel wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    if (!i_mode) begin
      if ({1'b0, i_sel} < NCH_W) begin
        if (i_valid[i_sel]) begin
          w_found = 1'b1;
          w_gnt   = i_sel;
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        w_idx = {1'b0, r_rr_ptr} + (SELW+1)'(i);
        if (w_idx >= NCH_W) w_idx = w_idx - NCH_W;
        if (!w_found && i_valid[w_idx[SELW-1:0]]) begin
          w_found = 1'b1;
          w_gnt   = w_idx[SELW-1:0];
        end
      end
    end
  end

  // Ready is suppressed during reset so no producer sees a handshake that gets discarded.
  assign w_xfer = w_found && w_can_load && !i_rst;

  always_comb begin
    w_ready = '0;
    if (w_xfer) w_ready[w_gnt] = 1'b1;
  end

  assign o_ready    = w_ready;
  assign w_data     = i_data[w_gnt*WIDTH +: WIDTH];
  assign w_next_ptr = (w_gnt == LAST_CH) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_y      <= '0;
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_y     <= w_data;
      r_ch    <= w_gnt;
      r_valid <= 1'b1;
      if (i_mode) r_rr_ptr <= w_next_ptr;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUXN_PARITY_EN
  logic r_par;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_par <= 1'b0;
    end else if (w_xfer) begin
      r_par <= ^w_data;
    end
  end

  assign o_par = r_par;
`endif

  assign o_y     = r_y;
  assign o_valid = r_valid;
  assign o_ch    = r_ch;

endmodule

// File: tb/tb_muxn_hs_reg.sv
// tb/tb_muxn_hs_reg.sv - self-checking bench for muxn_hs_reg (4-channel model, 3-channel select/parity)
// Parity checks are compiled in when MUXN_PARITY_EN is defined.
module tb_muxn_hs_reg;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        mode;
  logic [1:0]  sel;
  logic [31:0] data;
  logic [3:0]  valid;
  logic        rdy;
  logic [3:0]  ready_o;
  logic [7:0]  y_o;
  logic        valid_o;
  logic [1:0]  ch_o;
  logic        par_o;

  logic        d3_mode;
  logic [1:0]  d3_sel;
  logic [23:0] d3_data;
  logic [2:0]  d3_valid;
  logic        d3_rdy;
  logic [2:0]  d3_ready_o;
  logic [7:0]  d3_y_o;
  logic        d3_valid_o;
  logic [1:0]  d3_ch_o;
  logic        d3_par_o;

  muxn_hs_reg #(.WIDTH(8), .NCH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_data(data),
    .i_valid(valid), .o_ready(ready_o), .o_y(y_o), .o_valid(valid_o),
    .i_ready(rdy), .o_ch(ch_o)
`ifdef MUXN_PARITY_EN
    , .o_par(par_o)
`endif
  );

  muxn_hs_reg #(.WIDTH(8), .NCH(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_mode(d3_mode), .i_sel(d3_sel), .i_data(d3_data),
    .i_valid(d3_valid), .o_ready(d3_ready_o), .o_y(d3_y_o), .o_valid(d3_valid_o),
    .i_ready(d3_rdy), .o_ch(d3_ch_o)
`ifdef MUXN_PARITY_EN
    , .o_par(d3_par_o)
`endif
  );

`ifndef MUXN_PARITY_EN
  assign par_o    = 1'b0;
  assign d3_par_o = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state for the 4-channel instance
  logic [7:0] m_y;
  logic       m_valid;
  int         m_ch;
  int         m_ptr;
  logic       m_par;
  int         last_acc;
  logic [3:0] obs_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input logic md, input int s, input logic [3:0] v, input int ptr);
    if (!md) return (s < 4 && v[s]) ? s : -1;
    for (int off = 0; off < 4; off++) begin
      int c;
      c = (ptr + off) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_y = 8'h00; m_valid = 1'b0; m_ch = 0; m_ptr = 0; m_par = 1'b0;
  endtask

  // Called just after a falling edge: drive, check ready, clock, check outputs.
  task automatic step(input logic md, input logic [1:0] s, input logic [31:0] d,
                      input logic [3:0] v, input logic r);
    int  g;
    logic can;
    logic [3:0] exp_rdy;
    mode = md; sel = s; data = d; valid = v; rdy = r;
    #1;
    g = exp_grant(md, int'(s), v, m_ptr);
    can = !m_valid || r;
    exp_rdy = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
    obs_ready = ready_o;
    check("o_ready", ready_o, exp_rdy);
    @(posedge clk);
    last_acc = -1;
    if (can && g >= 0) begin
      m_y = d[g*8 +: 8]; m_ch = g; m_valid = 1'b1; m_par = ^d[g*8 +: 8];
      if (md) m_ptr = (g + 1) % 4;
      last_acc = g;
    end else if (r) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check("o_valid", valid_o, m_valid);
    check("o_y", y_o, m_y);
    check("o_ch", ch_o, m_ch);
`ifdef MUXN_PARITY_EN
    check("o_par", par_o, m_par);
`endif
  endtask

  task automatic step3(input logic [1:0] s, input logic [23:0] d, input logic [2:0] v,
                       input logic [2:0] exp_rdy);
    d3_mode = 1'b0; d3_sel = s; d3_data = d; d3_valid = v; d3_rdy = 1'b1;
    #1;
    check("d3_o_ready", d3_ready_o, exp_rdy);
    @(negedge clk);
  endtask

  logic [7:0] pd [4];
  logic [3:0] pv;
  logic       rmode;

  initial begin
    rst = 1'b1;
    mode = 1'b0; sel = 2'd0; data = '0; valid = '0; rdy = 1'b1;
    d3_mode = 1'b0; d3_sel = 2'd0; d3_data = '0; d3_valid = '0; d3_rdy = 1'b1;
    model_reset();
    #1;
    check("rst_o_valid", valid_o, 1'b0);
    check("rst_o_y", y_o, 8'h00);
    check("rst_o_ch", ch_o, 2'd0);
    check("rst_o_ready", ready_o, 4'b0000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Round-robin fairness, all channels valid
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 32'hA3A2A1A0, 4'b1111, 1'b1);
      check("rr_ch", ch_o, 32'(i % 4));
      check("rr_y", y_o, 32'(8'hA0 + i % 4));
      check("rr_nobubble", valid_o, 1'b1);
    end

    // Sparse round-robin starting with pointer at 2
    step(1'b1, 2'd0, 32'h00000B00, 4'b0010, 1'b1);
    check("sp_setup_ch", ch_o, 2'd1);
    step(1'b1, 2'd0, 32'h33001100, 4'b1010, 1'b1);
    check("sp_first", ch_o, 2'd3);
    step(1'b1, 2'd0, 32'h33001100, 4'b1010, 1'b1);
    check("sp_wrap", ch_o, 2'd1);
    step(1'b1, 2'd0, 32'h33001100, 4'b1010, 1'b1);
    check("sp_third", ch_o, 2'd3);

    // Fixed select
    step(1'b0, 2'd1, 32'h00000301, 4'b0011, 1'b1);
    check("fs_ready", obs_ready, 4'b0010);
    check("fs_y1", y_o, 8'h03);
    check("fs_ch1", ch_o, 2'd1);
    step(1'b0, 2'd0, 32'h00000301, 4'b0011, 1'b1);
    check("fs_y0", y_o, 8'h01);
    check("fs_ch0", ch_o, 2'd0);

    // Backpressure
    step(1'b0, 2'd2, 32'h00AA0000, 4'b0100, 1'b1);
    check("bp_load", y_o, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd2, 32'h00550000, 4'b0100, 1'b0);
      check("bp_ready", obs_ready, 4'b0000);
      check("bp_hold", y_o, 8'hAA);
      check("bp_valid", valid_o, 1'b1);
    end
    step(1'b0, 2'd2, 32'h00550000, 4'b0100, 1'b1);
    check("bp_release", y_o, 8'h55);
    step(1'b0, 2'd2, 32'h00000000, 4'b0000, 1'b1);
    check("bp_drain", valid_o, 1'b0);

    // Asynchronous reset mid-cycle
    step(1'b0, 2'd3, 32'h77000000, 4'b1000, 1'b1);
    mode = 1'b0; sel = 2'd0; data = 32'h00000011; valid = 4'b0001; rdy = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_o_valid", valid_o, 1'b0);
    check("arst_o_y", y_o, 8'h00);
    check("arst_o_ch", ch_o, 2'd0);
    check("arst_o_ready", ready_o, 4'b0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range select on the 3-channel instance
    step3(2'd0, 24'h00000F, 3'b111, 3'b001);
    check("d3_load_y", d3_y_o, 8'h0F);
    step3(2'd3, 24'h0000A1, 3'b111, 3'b000);
    check("d3_oor_valid", d3_valid_o, 1'b0);
    check("d3_oor_hold_y", d3_y_o, 8'h0F);
    step3(2'd0, 24'h0000A1, 3'b001, 3'b001);
    check("d3_y", d3_y_o, 8'hA1);
    check("d3_ch", d3_ch_o, 2'd0);
`ifdef MUXN_PARITY_EN
    check("d3_par", d3_par_o, 1'b1);
`endif

    // Randomized traffic with producers holding until accepted
    pv = 4'b0000;
    rmode = 1'b1;
    for (int k = 0; k < 4; k++) pd[k] = 8'h00;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pv[k] && ($urandom_range(1, 0) == 1)) begin
          pv[k] = 1'b1;
          pd[k] = 8'($urandom);
        end
      end
      if ($urandom_range(15, 0) == 0) rmode = ~rmode;
      step(rmode, 2'($urandom), {pd[3], pd[2], pd[1], pd[0]}, pv,
           ($urandom_range(3, 0) != 0));
      if (last_acc >= 0) pv[last_acc] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
